pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the architectural PC register and drives instruction fetch; the counterpart of the next-PC adder/mux.
//  - Publishes curr_pc to the next-PC logic.
//  - Consumes next_pc_in: PC+4, or the jump target when a jump resolves.
//  - Issues one imem request at a time; buffers the returned word for decode behind a valid/ready handshake.
//  - Discards in-flight fetches on redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
// PORTS
//  clock        in   1   single clock, all state updates on posedge
//  reset        in   1   synchronous, active-high
//  next_pc_in   in   32  next PC from next-PC logic (curr_pc+4 or jump target)
//  redirect     in   1   jump taken this cycle; next_pc_in holds target
//  curr_pc      out  32  architectural PC register
//  imem_req     out  1   fetch request valid
//  imem_addr    out  32  word-aligned fetch address {curr_pc[31:2],2'b00}
//  imem_gnt     in   1   request accepted this cycle (only meaningful with imem_req)
//  imem_rvalid  in   1   response data valid (earliest 1 cycle after gnt)
//  imem_rdata   in   32  instruction word
//  inst_valid   out  1   decode-side instruction valid
//  inst         out  32  buffered instruction
//  inst_pc      out  32  PC of buffered instruction
//  inst_ready   in   1   decode accepts inst this cycle
//  fetch_misalign out 1  only with FETCH_ALIGN_CHECK_EN (else tied 0)
// BEHAVIOUR
//  Reset values (reset high at a posedge):
//  - curr_pc=RESET_PC; imem_req=0; inst_valid=0; drop=0; state=IDLE.
//  - Reset wins over every other input; reset mid-fetch abandons the transaction; a late rvalid is ignored while in IDLE.
//  FSM states IDLE, REQ, WAIT (plus FAULT with FETCH_ALIGN_CHECK_EN):
//  - IDLE -> REQ on the cycle after reset deasserts.
//  - REQ: imem_req=1. On gnt -> WAIT.
//    - Request is issued only while the out buffer is empty or being drained (inst_valid & inst_ready); otherwise imem_req=0.
//  - WAIT: imem_req=0. On rvalid:
//    - inst<=rdata, inst_pc<=curr_pc, inst_valid<=1.
//    - curr_pc<=next_pc_in; -> REQ.
//  - Throughput: one instruction per 2 cycles minimum (gnt same cycle as req, rvalid next cycle).
//  Out buffer:
//  - inst_valid stays 1, and inst/inst_pc stay stable, until inst_ready.
//  - Fill and drain in the same cycle keeps inst_valid=1 with the new word.
//  Redirect (highest priority after reset) in any state:
//  - curr_pc<=next_pc_in; inst_valid<=0.
//  - In REQ without gnt: stay REQ; imem_addr changes next cycle.
//  - In REQ with gnt same cycle, or in WAIT without rvalid: drop<=1.
//    - The next rvalid is discarded (no buffer write, no PC update) and clears drop -> REQ.
//  - In WAIT with rvalid same cycle: response discarded; -> REQ.
//  - Redirect while drop=1: drop stays 1; curr_pc takes the newest target.
//  Arithmetic: no adder here; all PC math lives in next-PC logic. curr_pc is 32-bit and wraps naturally.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//  - On entering REQ with curr_pc[1:0]!=0, no request is issued.
//  - fetch_misalign<=1 and the FSM goes to FAULT.
//  - FAULT holds until redirect (-> REQ, fetch_misalign<=0) or reset.
//  FETCH_ALIGN_CHECK_EN undefined:
//  - curr_pc[1:0] is ignored for addressing; fetch_misalign is tied 0; FAULT does not exist.
// STRUCTURE
//  Shared package fetch_pkg:
//  - fetch state encoding localparams (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, FAULT=2'd3).
//  - MIPS_WORD_W=32 and default RESET_PC.
//  Sub-module fetch_buf: one-entry valid/ready holding register (inst, inst_pc) with load/drain/flush inputs.
//  FSM and PC register stay in pc_fetch_unit.
// TESTING
//  1 Reset with RESET_PC=0x100, imem grants immediately, rvalid 1 cycle later, inst_ready=1:
//    -> addresses 0x100, 0x104, 0x108; inst_pc matches each; new inst every 2 cycles.
//  2 inst_ready=0 for 5 cycles after the first word:
//    -> inst/inst_pc stable; imem_req stays 0 until inst_ready=1, then 0x104 is requested.
//  3 redirect with target 0x400 while in WAIT for 0x104:
//    -> that response is dropped, inst_valid=0, next imem_addr=0x400.
//  4 redirect in the same cycle as rvalid for 0x108, target 0x200:
//    -> word not delivered; curr_pc=0x200; next request to 0x200.
//  5 reset asserted in WAIT, rvalid the next cycle:
//    -> response ignored; curr_pc=RESET_PC; inst_valid=0.
//  6 FETCH_ALIGN_CHECK_EN defined, redirect to 0x402:
//    -> no imem_req, fetch_misalign=1; redirect to 0x500 clears it and 0x500 is fetched.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// FETCH_ALIGN_CHECK_EN adds the FAULT state used by the misaligned-PC check.
package fetch_pkg;

    localparam int unsigned MIPS_WORD_W = 32;
    localparam logic [MIPS_WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2
    } fetch_state_e;
`endif

    function automatic logic [MIPS_WORD_W-1:0] word_addr(input logic [MIPS_WORD_W-1:0] pc);
        return {pc[MIPS_WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bus bundles for the fetch unit: imem request/response and the decode-side handshake.
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input imem_gnt, input imem_rvalid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr,
                    output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

interface inst_if;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);
endinterface

// File: rtl/fetch_buf.sv
// One-entry valid/ready holding register for a fetched instruction and its PC.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   drain,
    input  logic                   flush,
    input  logic [MIPS_WORD_W-1:0] load_inst,
    input  logic [MIPS_WORD_W-1:0] load_pc,
    output logic                   valid,
    output logic [MIPS_WORD_W-1:0] inst,
    output logic [MIPS_WORD_W-1:0] inst_pc
);

    // Load wins over drain so a same-cycle fill/drain keeps the entry valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (load && !flush) begin
            inst    <= load_inst;
            inst_pc <= load_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and single-outstanding instruction fetch FSM.
// FETCH_ALIGN_CHECK_EN enables the misaligned-PC fault path.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [MIPS_WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [MIPS_WORD_W-1:0] next_pc_in,
    input  logic                   redirect,
    output logic [MIPS_WORD_W-1:0] curr_pc,
    imem_if.master                 imem,
    inst_if.master                 dec,
    output logic                   fetch_misalign
);

    fetch_state_e           state, state_next;
    logic                   drop, drop_next;
    logic [MIPS_WORD_W-1:0] pc_next;
    logic                   buf_load, buf_flush;
    logic                   can_issue, granted;

    assign imem.imem_addr = word_addr(curr_pc);
    assign can_issue      = !dec.inst_valid || dec.inst_ready;
    assign granted        = imem.imem_req && imem.imem_gnt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_next;
    logic misaligned;
    assign misaligned = (curr_pc[1:0] != 2'b00);
`endif

    always_comb begin
        state_next    = state;
        drop_next     = drop;
        pc_next       = curr_pc;
        buf_load      = 1'b0;
        buf_flush     = 1'b0;
        imem.imem_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_next = fetch_misalign;
`endif
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (misaligned) begin
                    state_next    = FAULT;
                    misalign_next = 1'b1;
                end else
`endif
                if (can_issue) begin
                    imem.imem_req = 1'b1;
                    if (imem.imem_gnt) state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_next = REQ;
                    if (drop) begin
                        drop_next = 1'b0;
                    end else begin
                        buf_load = 1'b1;
                        pc_next  = next_pc_in;
                    end
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: state_next = FAULT;
`endif
            default: state_next = IDLE;
        endcase

        // Redirect overrides the normal path; an in-flight fetch is marked
        // for discard so its response never reaches decode or moves the PC.
        if (redirect) begin
            pc_next   = next_pc_in;
            buf_flush = 1'b1;
            buf_load  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_next = 1'b0;
`endif
            case (state)
                REQ: begin
                    if (granted) drop_next = 1'b1;
                    else         state_next = REQ;
                end
                WAIT:    drop_next = imem.imem_rvalid ? 1'b0 : 1'b1;
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            curr_pc <= RESET_PC;
            drop    <= 1'b0;
        end else begin
            state   <= state_next;
            curr_pc <= pc_next;
            drop    <= drop_next;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) fetch_misalign <= 1'b0;
        else       fetch_misalign <= misalign_next;
    end
`else
    assign fetch_misalign = 1'b0;
`endif

    fetch_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .load      (buf_load),
        .drain     (dec.inst_valid && dec.inst_ready),
        .flush     (buf_flush),
        .load_inst (imem.imem_rdata),
        .load_pc   (curr_pc),
        .valid     (dec.inst_valid),
        .inst      (dec.inst),
        .inst_pc   (dec.inst_pc)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit; the FETCH_ALIGN_CHECK_EN build adds the fault scenario.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc_in;
    logic [31:0] curr_pc;
    logic        fetch_misalign;

    imem_if imem ();
    inst_if dec ();

    int unsigned asserts = 0;
    int unsigned fails   = 0;
    int unsigned cyc     = 0;
    int unsigned resp_delay = 0;
    int unsigned last_cyc = 0;
    int unsigned prev_cyc = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Next-PC logic stand-in: sequential PC+4 unless a jump target is driven.
    assign next_pc_in = redirect ? target : curr_pc + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clock          (clock),
        .reset          (reset),
        .next_pc_in     (next_pc_in),
        .redirect       (redirect),
        .curr_pc        (curr_pc),
        .imem           (imem.master),
        .dec            (dec.master),
        .fetch_misalign (fetch_misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        chk("reset_curr_pc", curr_pc, 32'h0000_0100);
        chk("reset_imem_req", {31'b0, imem.imem_req}, 32'd0);
        chk("reset_inst_valid", {31'b0, dec.inst_valid}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_addr_drained(input string tag);
        int unsigned n = 0;
        while (exp_addr.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic wait_pc_drained(input string tag);
        int unsigned n = 0;
        while (exp_pc.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_pc.size()), 32'd0);
    endtask

    // Memory responder: grants only addresses the scoreboard expects, answers after resp_delay.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int unsigned cnt;
        pend = 1'b0;
        pend_addr = '0;
        cnt = 0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        forever begin
            @(negedge clock);
            imem.imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem.imem_rvalid = 1'b1;
                    imem.imem_rdata  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem.imem_req && exp_addr.size() != 0) begin
                imem.imem_gnt = 1'b1;
                chk("imem_addr", imem.imem_addr, exp_addr.pop_front());
                pend      = 1'b1;
                pend_addr = imem.imem_addr;
                cnt       = resp_delay;
            end else begin
                imem.imem_gnt = 1'b0;
            end
        end
    end

    // Decode-side consumer: every accepted instruction must match the scoreboard head.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (dec.inst_valid && dec.inst_ready) begin
                asserts++;
                assert (exp_pc.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_inst: observed pc %h expected none", dec.inst_pc);
                end
                if (exp_pc.size() != 0) begin
                    e = exp_pc.pop_front();
                    chk("inst_pc", dec.inst_pc, e);
                    chk("inst", dec.inst, mem_word(e));
                    prev_cyc = last_cyc;
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        target = '0;
        dec.inst_ready = 1'b1;

        // 1: streaming fetch from RESET_PC
        resp_delay = 0;
        do_reset();
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104); exp_addr.push_back(32'h108);
        exp_pc.push_back(32'h100);   exp_pc.push_back(32'h104);   exp_pc.push_back(32'h108);
        wait_pc_drained("t1_delivered");
        chk("t1_throughput", last_cyc - prev_cyc, 32'd2);
`ifndef FETCH_ALIGN_CHECK_EN
        chk("misalign_tied", {31'b0, fetch_misalign}, 32'd0);
`endif

        // 2: decode back-pressure holds the buffer and blocks new requests
        dec.inst_ready = 1'b0;
        do_reset();
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_pc.push_back(32'h100);   exp_pc.push_back(32'h104);
        for (int i = 0; i < 40 && !dec.inst_valid; i++) tick();
        chk("t2_valid", {31'b0, dec.inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_req_held", {31'b0, imem.imem_req}, 32'd0);
            chk("t2_pc_stable", dec.inst_pc, 32'h100);
            chk("t2_inst_stable", dec.inst, mem_word(32'h100));
            tick();
        end
        chk("t2_addr_pending", 32'(exp_addr.size()), 32'd1);
        dec.inst_ready = 1'b1;
        wait_pc_drained("t2_delivered");

        // 3: redirect while waiting on a slow response
        resp_delay = 2;
        do_reset();
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        exp_pc.push_back(32'h100);
        wait_addr_drained("t3_reach_wait");
        redirect = 1'b1; target = 32'h400;
        exp_addr.push_back(32'h400);
        exp_pc.push_back(32'h400);
        tick();
        redirect = 1'b0;
        chk("t3_curr_pc", curr_pc, 32'h400);
        chk("t3_inst_valid", {31'b0, dec.inst_valid}, 32'd0);
        wait_pc_drained("t3_delivered");

        // 4: redirect coinciding with rvalid
        resp_delay = 0;
        do_reset();
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104); exp_addr.push_back(32'h108);
        exp_pc.push_back(32'h100);   exp_pc.push_back(32'h104);
        wait_addr_drained("t4_reach_wait");
        redirect = 1'b1; target = 32'h200;
        exp_addr.push_back(32'h200);
        exp_pc.push_back(32'h200);
        tick();
        redirect = 1'b0;
        chk("t4_curr_pc", curr_pc, 32'h200);
        chk("t4_inst_valid", {31'b0, dec.inst_valid}, 32'd0);
        wait_pc_drained("t4_delivered");

        // 5: reset in WAIT, response arrives while IDLE
        resp_delay = 1;
        do_reset();
        exp_addr.push_back(32'h100);
        wait_addr_drained("t5_reach_wait");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_reset_req", {31'b0, imem.imem_req}, 32'd0);
        tick();
        chk("t5_curr_pc", curr_pc, 32'h100);
        chk("t5_inst_valid", {31'b0, dec.inst_valid}, 32'd0);
        tick();
        chk("t5_req_again", {31'b0, imem.imem_req}, 32'd1);
        chk("t5_addr_again", imem.imem_addr, 32'h100);
        chk("t5_no_delivery", {31'b0, dec.inst_valid}, 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
        // 6: misaligned target faults until a fresh redirect
        resp_delay = 0;
        do_reset();
        exp_addr.push_back(32'h100);
        wait_addr_drained("t6_reach_wait");
        redirect = 1'b1; target = 32'h402;
        tick();
        redirect = 1'b0;
        chk("t6_curr_pc", curr_pc, 32'h402);
        chk("t6_no_req", {31'b0, imem.imem_req}, 32'd0);
        tick();
        chk("t6_misalign", {31'b0, fetch_misalign}, 32'd1);
        chk("t6_fault_no_req", {31'b0, imem.imem_req}, 32'd0);
        exp_addr.push_back(32'h500);
        exp_pc.push_back(32'h500);
        redirect = 1'b1; target = 32'h500;
        tick();
        redirect = 1'b0;
        chk("t6_misalign_clr", {31'b0, fetch_misalign}, 32'd0);
        wait_pc_drained("t6_delivered");
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
